fir_feed_master: RTL and testbench

Stream master that drives the FIR filter's sample/config port (x_n, s_set_coeffs, s_axis_fir_tvalid). It holds a shadow coefficient bank written by the host and, on request, replays it into the filter's tap shift chain. It buffers incoming samples in a small FIFO and emits them as contiguous valid beats. It sits between the chip I/O decode logic and the FIR instance.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_feed_master_if.sv | 41 ++++
 rtl/fir_feed_fifo.sv | 73 +++++++
 rtl/fir_feed_master.sv | 166 ++++++++++++++++
 tb/tb_fir_feed_master.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg
//   Shared definitions for the FIR feed path: default widths and tap count,
//   the feed-master state encoding and the length of the post-load gap.
package fir_pkg;

  localparam int TAP_SIZE_DEF    = 6;
  localparam int NBR_OF_TAPS_DEF = 3;
  localparam int X_N_SIZE_DEF    = 8;
  localparam int FIFO_DEPTH_DEF  = 4;

  // Idle beats after a coefficient load so the FIR can leave its CONFIG mode.
  localparam int GAP_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01,
    LOAD   = 2'b10,
    GAP    = 2'b11
  } feed_state_e;

  function automatic logic state_is_busy(feed_state_e s);
    return (s == LOAD) || (s == GAP);
  endfunction

endpackage

// File: rtl/fir_feed_master_if.sv
// fir_feed_master_if
//   Groups the upstream sample handshake and the FIR sample/config port.
//   master : the feed master (consumes in_*, drives in_ready and the FIR port)
//   slave  : the environment (drives in_valid/in_data, observes the rest)
//   Signals:
//     in_valid, in_data, in_ready  upstream valid/ready sample stream
//     x_n                          sample or sign-extended coefficient to FIR
//     s_set_coeffs                 high on coefficient load beats
//     s_axis_fir_tvalid            high on sample beats
interface fir_feed_master_if
  import fir_pkg::*;
#(
  parameter int X_N_SIZE = X_N_SIZE_DEF
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic signed [X_N_SIZE-1:0] in_data;
  logic signed [X_N_SIZE-1:0] x_n;
  logic                       s_set_coeffs;
  logic                       s_axis_fir_tvalid;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output x_n,
    output s_set_coeffs,
    output s_axis_fir_tvalid
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  x_n,
    input  s_set_coeffs,
    input  s_axis_fir_tvalid
  );

endinterface

// File: rtl/fir_feed_fifo.sv
// fir_feed_fifo
//   Synchronous sample FIFO with occupancy count. Read data is the head entry,
//   valid whenever empty is low, so a pop and its data share one cycle.
//   Ports:
//     clk, reset        clock, synchronous active-high reset (flushes FIFO)
//     push, wr_data     write request and data (ignored when full)
//     pop, rd_data      read request (ignored when empty) and head data
//     full, empty       status from the registered count
//     count             current occupancy, 0..DEPTH
module fir_feed_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = X_N_SIZE_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fir_feed_master.sv
// fir_feed_master
//   Drives the FIR sample/config port. Keeps a host-written shadow bank of
//   NBR_OF_TAPS signed coefficients and, on request, replays it highest index
//   first so coef[i] lands in FIR tap i, followed by GAP_CYCLES idle beats.
//   Between loads, buffered samples are streamed as contiguous valid beats.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     bus (master)        upstream sample handshake and FIR x_n/config/valid
//     coef_wr/addr/data   shadow coefficient write (only in IDLE or STREAM)
//     load_req            one-cycle request to replay the coefficient bank
//     busy                high on load and gap beats
//     fifo_count          sample FIFO occupancy
module fir_feed_master
  import fir_pkg::*;
#(
  parameter int TAP_SIZE    = TAP_SIZE_DEF,
  parameter int NBR_OF_TAPS = NBR_OF_TAPS_DEF,
  parameter int X_N_SIZE    = X_N_SIZE_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  fir_feed_master_if.master                bus,
  input  logic                             coef_wr,
  input  logic [$clog2(NBR_OF_TAPS)-1:0]   coef_addr,
  input  logic signed [TAP_SIZE-1:0]       coef_data,
  input  logic                             load_req,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);

  localparam int AW    = $clog2(NBR_OF_TAPS);
  localparam int CNT_W = $clog2(NBR_OF_TAPS + GAP_CYCLES) + 1;

  feed_state_e                state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       pending_q, pending_d;
  logic signed [TAP_SIZE-1:0] coef_q [NBR_OF_TAPS];
  logic signed [TAP_SIZE-1:0] coef_d [NBR_OF_TAPS];
  logic signed [X_N_SIZE-1:0] x_n_q, x_n_d;
  logic                       set_q, set_d;
  logic                       tvalid_q, tvalid_d;
  logic                       busy_q, busy_d;
  logic [AW-1:0]              tap_idx;
  logic                       coef_wr_ok;

  logic                       fifo_push, fifo_pop;
  logic                       fifo_full, fifo_empty;
  logic [X_N_SIZE-1:0]        fifo_rd;

  assign fifo_push    = bus.in_valid && !fifo_full;
  assign bus.in_ready = !fifo_full;

  fir_feed_fifo #(
    .WIDTH (X_N_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (bus.in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Shadow bank is frozen during LOAD and GAP so a replay never mixes old and
  // new coefficients.
  always_comb begin
    coef_wr_ok = coef_wr && ((state_q == IDLE) || (state_q == STREAM)) &&
                 (32'(coef_addr) < NBR_OF_TAPS);
    coef_d = coef_q;
    if (coef_wr_ok) coef_d[coef_addr] = coef_data;
  end

  // Next-state and output decode. Outputs are computed from the current state
  // and registered, so each beat appears on the port one edge after its state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q | (load_req && (state_q != IDLE));
    fifo_pop  = 1'b0;
    x_n_d     = '0;
    set_d     = 1'b0;
    tvalid_d  = 1'b0;
    busy_d    = state_is_busy(state_q);
    tap_idx   = cnt_q[AW-1:0];

    unique case (state_q)
      IDLE: begin
        if (load_req || pending_q) begin
          state_d = LOAD;
          cnt_d   = CNT_W'(NBR_OF_TAPS - 1);
        end else if (!fifo_empty) begin
          // First sample pops on the transition so it is not delayed a beat.
          fifo_pop = 1'b1;
          x_n_d    = $signed(fifo_rd);
          tvalid_d = 1'b1;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (pending_q) begin
          // The beat emitted from this cycle is the single idle beat that
          // separates the stream from the load.
          state_d = LOAD;
          cnt_d   = CNT_W'(NBR_OF_TAPS - 1);
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          x_n_d    = $signed(fifo_rd);
          tvalid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        set_d = 1'b1;
        x_n_d = X_N_SIZE'(coef_q[tap_idx]);
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Any number of requests seen before a load starts collapse into it.
    if ((state_d == LOAD) && (state_q != LOAD)) pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      x_n_q     <= '0;
      set_q     <= 1'b0;
      tvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NBR_OF_TAPS; i++) coef_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      x_n_q     <= x_n_d;
      set_q     <= set_d;
      tvalid_q  <= tvalid_d;
      busy_q    <= busy_d;
      coef_q    <= coef_d;
    end
  end

  assign bus.x_n               = x_n_q;
  assign bus.s_set_coeffs      = set_q;
  assign bus.s_axis_fir_tvalid = tvalid_q;
  assign busy                  = busy_q;

endmodule

// File: tb/tb_fir_feed_master.sv
// tb_fir_feed_master
//   Directed bench for fir_feed_master with hand-computed expectations.
//   Output vectors are packed as {tvalid, s_set_coeffs, busy, x_n}.
module tb_fir_feed_master;

  logic              clk = 1'b0;
  logic              reset;
  logic              coef_wr;
  logic [1:0]        coef_addr;
  logic signed [5:0] coef_data;
  logic              load_req;
  logic              busy;
  logic [2:0]        fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_feed_master_if #(.X_N_SIZE(8)) bus ();

  fir_feed_master #(
    .TAP_SIZE    (6),
    .NBR_OF_TAPS (3),
    .X_N_SIZE    (8),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .coef_wr    (coef_wr),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .load_req   (load_req),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  function automatic logic [10:0] outs();
    return {bus.s_axis_fir_tvalid, bus.s_set_coeffs, busy, bus.x_n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h55;
    coef_wr = 1'b0; coef_addr = 2'd0; coef_data = 6'h00; load_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({outs(), bus.in_ready} !== {11'h000, 1'b1}) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %h required %h", i, {outs(), bus.in_ready}, {11'h000, 1'b1});
      end
    end
    reset = 1'b0; bus.in_valid = 1'b0;
    tick();
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_fifo_count: got %0d required 0", fifo_count);
    end
    checks++;
    if (outs() !== 11'h000) begin
      errors++;
      $display("FAIL post_reset_outputs: got %h required 000", outs());
    end
  endtask

  task automatic test_load_basic();
    logic [7:0] exp_x [3];
    exp_x = '{8'h03, 8'hFF, 8'h05};
    coef_wr = 1'b1;
    coef_addr = 2'd0; coef_data = 6'h05; tick();
    coef_addr = 2'd1; coef_data = 6'h3F; tick();
    coef_addr = 2'd2; coef_data = 6'h03; tick();
    coef_wr = 1'b0; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    checks++;
    if (outs() !== 11'h000) begin
      errors++;
      $display("FAIL load_latency: got %h required 000", outs());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs() !== {1'b0, 1'b1, 1'b1, exp_x[i]}) begin
        errors++;
        $display("FAIL load_beat%0d: got %h required %h", i, outs(), {1'b0, 1'b1, 1'b1, exp_x[i]});
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs() !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
        errors++;
        $display("FAIL gap_beat%0d: got %h required %h", i, outs(), {1'b0, 1'b0, 1'b1, 8'h00});
      end
    end
    tick();
    checks++;
    if (outs() !== 11'h000) begin
      errors++;
      $display("FAIL load_end_idle: got %h required 000", outs());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals = '{8'd10, 8'd20, 8'd30};
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = vals[i];
      tick();
      checks++;
      if (i == 0) begin
        if ({outs(), fifo_count} !== {11'h000, 3'd1}) begin
          errors++;
          $display("FAIL stream_first_accept: got %h required %h", {outs(), fifo_count}, {11'h000, 3'd1});
        end
      end else if (outs() !== {1'b1, 1'b0, 1'b0, vals[i-1]}) begin
        errors++;
        $display("FAIL stream_beat%0d: got %h required %h", i - 1, outs(), {1'b1, 1'b0, 1'b0, vals[i-1]});
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if ({outs(), bus.in_ready} !== {1'b1, 1'b0, 1'b0, 8'd30, 1'b1}) begin
      errors++;
      $display("FAIL stream_beat2: got %h required %h", {outs(), bus.in_ready}, {1'b1, 1'b0, 1'b0, 8'd30, 1'b1});
    end
    tick();
    checks++;
    if ({outs(), fifo_count} !== {11'h000, 3'd0}) begin
      errors++;
      $display("FAIL stream_end: got %h required %h", {outs(), fifo_count}, {11'h000, 3'd0});
    end
  endtask

  // Starts a load while pushing four samples, so the FIFO fills during LOAD.
  task automatic fill_during_load(input logic [7:0] base);
    load_req = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = base + 8'(i);
      tick();
      load_req = 1'b0;
    end
  endtask

  task automatic test_fifo_full();
    fill_during_load(8'h11);
    bus.in_data = 8'h99;
    checks++;
    if ({fifo_count, bus.in_ready, bus.s_set_coeffs} !== {3'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL fifo_full: got %h required %h", {fifo_count, bus.in_ready, bus.s_set_coeffs}, {3'd4, 1'b0, 1'b1});
    end
    tick(); tick();
    checks++;
    if ({fifo_count, bus.in_ready} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL fifo_hold_full: got %h required %h", {fifo_count, bus.in_ready}, {3'd4, 1'b0});
    end
    tick();
    checks++;
    if ({outs(), fifo_count} !== {1'b1, 1'b0, 1'b0, 8'h11, 3'd3}) begin
      errors++;
      $display("FAIL full_pop_no_push: got %h required %h", {outs(), fifo_count}, {1'b1, 1'b0, 1'b0, 8'h11, 3'd3});
    end
    bus.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if ({outs(), bus.in_ready} !== {1'b1, 1'b0, 1'b0, 8'h11 + 8'(i), 1'b1}) begin
        errors++;
        $display("FAIL drain_beat%0d: got %h required %h", i, {outs(), bus.in_ready}, {1'b1, 1'b0, 1'b0, 8'h11 + 8'(i), 1'b1});
      end
    end
    tick();
    checks++;
    if ({outs(), fifo_count} !== {11'h000, 3'd0}) begin
      errors++;
      $display("FAIL drain_end: got %h required %h", {outs(), fifo_count}, {11'h000, 3'd0});
    end
  endtask

  task automatic test_mid_stream_load();
    logic [10:0] exp_t [10];
    exp_t = '{{3'b100, 8'h42}, {3'b000, 8'h00}, {3'b011, 8'h03}, {3'b011, 8'hFF},
              {3'b011, 8'h05}, {3'b001, 8'h00}, {3'b001, 8'h00}, {3'b100, 8'h43},
              {3'b100, 8'h44}, {3'b000, 8'h00}};
    fill_during_load(8'h41);
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (outs() !== {3'b100, 8'h41}) begin
      errors++;
      $display("FAIL midstream_first: got %h required %h", outs(), {3'b100, 8'h41});
    end
    load_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      load_req = 1'b0;
      checks++;
      if (outs() !== exp_t[i]) begin
        errors++;
        $display("FAIL midstream_step%0d: got %h required %h", i, outs(), exp_t[i]);
      end
    end
  endtask

  task automatic test_coef_wr_during_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    coef_wr = 1'b1; coef_addr = 2'd1; coef_data = 6'h07;
    tick();
    coef_wr = 1'b0;
    tick();
    checks++;
    if (outs() !== {3'b011, 8'hFF}) begin
      errors++;
      $display("FAIL wr_in_load_ignored: got %h required %h", outs(), {3'b011, 8'hFF});
    end
    tick(); tick(); tick(); tick();
    coef_wr = 1'b1; coef_addr = 2'd1; coef_data = 6'h07;
    tick();
    coef_wr = 1'b0; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick(); tick();
    checks++;
    if (outs() !== {3'b011, 8'h07}) begin
      errors++;
      $display("FAIL next_load_new_coef: got %h required %h", outs(), {3'b011, 8'h07});
    end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_pending_collapse();
    int n_set = 0;
    int n_both = 0;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int c = 2; c <= 18; c++) begin
      tick();
      n_set += int'(bus.s_set_coeffs);
      n_both += int'(bus.s_set_coeffs && bus.s_axis_fir_tvalid);
      load_req = (c == 2) || (c == 3);
    end
    checks++;
    if ({n_set, n_both} !== {32'd6, 32'd0}) begin
      errors++;
      $display("FAIL pending_collapse: got set_beats=%0d overlap=%0d required 6 and 0", n_set, n_both);
    end
    checks++;
    if (outs() !== 11'h000) begin
      errors++;
      $display("FAIL collapse_end_idle: got %h required 000", outs());
    end
  endtask

  task automatic test_reset_mid_op();
    int n_act = 0;
    load_req = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h77;
    tick();
    load_req = 1'b0; bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({outs(), fifo_count, bus.in_ready} !== {11'h000, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_abort: got %h required %h", {outs(), fifo_count, bus.in_ready}, {11'h000, 3'd0, 1'b1});
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_act += int'(bus.s_set_coeffs || bus.s_axis_fir_tvalid);
    end
    checks++;
    if (n_act !== 0) begin
      errors++;
      $display("FAIL reset_no_resume: got %0d active beats required 0", n_act);
    end
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs() !== {3'b011, 8'h00}) begin
        errors++;
        $display("FAIL reset_coef_cleared%0d: got %h required %h", i, outs(), {3'b011, 8'h00});
      end
    end
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_back_to_back();
    test_fifo_full();
    test_mid_stream_load();
    test_coef_wr_during_load();
    test_pending_collapse();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

endmodule
